// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared load/store types, access sizing and request legality
package cpu_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(mem_funct3_e f);
        case (f)
            MEM_H, MEM_HU: return 4'd2;
            MEM_W:         return 4'd4;
            default:       return 4'd1;
        endcase
    endfunction

    // Unknown encodings, unsigned stores and (optionally) unaligned halfword/word are refused
    function automatic logic req_legal(logic is_store, logic [2:0] f3, logic [1:0] addr_lo,
                                       logic align_check);
        logic ok;
        ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111) && !(is_store && f3[2]);
        if (align_check) begin
            if ((f3[1:0] == 2'b01) && addr_lo[0]) begin
                ok = 1'b0;
            end
            if ((f3[1:0] == 2'b10) && (addr_lo != 2'b00)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - size and sign extension of the low bytes of a fetched word
module lsu_extend
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Memory returns data starting at the access address, so only the low bytes matter
    always_comb begin
        ext = raw;
        case (funct3)
            MEM_B:   ext = {{24{raw[7]}}, raw[7:0]};
            MEM_BU:  ext = {24'd0, raw[7:0]};
            MEM_H:   ext = {{16{raw[15]}}, raw[15:0]};
            MEM_HU:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between execute and data memory
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ALIGN_CHECK  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_fetch_addr,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_bytes_to_write,
    input  logic [31:0] mem_fetched_data
);

    localparam logic [1:0] WAIT_INIT   = 2'(READ_LATENCY - 1);
    localparam logic       CHECK_ALIGN = (ALIGN_CHECK != 0);

    lsu_state_e  state_q;
    lsu_state_e  state_d;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  wait_cnt_q;
    logic        accept;
    logic        legal;
    logic [31:0] ext_data;

    assign accept = req_valid && req_ready;
    assign legal  = req_legal(req_is_store, req_funct3, req_addr[1:0], CHECK_ALIGN);

    lsu_extend u_extend (
        .funct3 (funct3_q),
        .raw    (mem_fetched_data),
        .ext    (ext_data)
    );

    // Request lifecycle: refused requests skip the memory and answer straight away
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = legal ? ISSUE : RESP;
            ISSUE:   state_d = is_store_q ? RESP : WAIT;
            WAIT:    if (wait_cnt_q == 2'd0) state_d = RESP;
            RESP:    if (resp_valid && resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs derived from the upcoming state; write strobe lives one cycle only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready          <= 1'b0;
            resp_valid         <= 1'b0;
            resp_rdata         <= '0;
            resp_error         <= 1'b0;
            mem_fetch_addr     <= '0;
            mem_write_addr     <= '0;
            mem_write_data     <= '0;
            mem_bytes_to_write <= '0;
            is_store_q         <= 1'b0;
            funct3_q           <= '0;
            wait_cnt_q         <= '0;
        end else begin
            req_ready          <= (state_d == IDLE);
            resp_valid         <= (state_d == RESP);
            mem_bytes_to_write <= 4'd0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        wait_cnt_q <= WAIT_INIT;
                        resp_rdata <= '0;
                        resp_error <= !legal;
                        if (legal && req_is_store) begin
                            mem_write_addr     <= req_addr;
                            mem_write_data     <= req_wdata;
                            mem_bytes_to_write <= size_bytes(mem_funct3_e'(req_funct3));
                        end
                        if (legal && !req_is_store) begin
                            mem_fetch_addr <= req_addr;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        resp_rdata <= ext_data;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - bench for load_store_unit across read latencies and alignment checking
module tb_load_store_unit;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_ready = 1'b1;

    logic        req_ready_a  [NI];
    logic        resp_valid_a [NI];
    logic [31:0] resp_rdata_a [NI];
    logic        resp_error_a [NI];
    logic [31:0] fetch_a      [NI];
    logic [31:0] waddr_a      [NI];
    logic [31:0] wdata_a      [NI];
    logic [3:0]  bwr_a        [NI];
    logic [31:0] fetched_a    [NI];
    int          wr_ev_a      [NI];

    logic [7:0]  ref_mem [NI][1024];
    logic [31:0] obs_rd  [NI];
    logic        obs_err [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int inst_rl(int g);
        return (g < 4) ? g + 1 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int RL = (g < 4) ? g + 1 : 1;
        localparam int AC = (g == 4) ? 1 : 0;
        logic [7:0]  mem  [1024];
        logic [31:0] pipe [4];
        int          wr_ev = 0;

        load_store_unit #(.READ_LATENCY(RL), .ALIGN_CHECK(AC)) u_dut (
            .clk                (clk),
            .rst                (rst),
            .req_valid          (req_valid),
            .req_ready          (req_ready_a[g]),
            .req_is_store       (req_is_store),
            .req_funct3         (req_funct3),
            .req_addr           (req_addr),
            .req_wdata          (req_wdata),
            .resp_valid         (resp_valid_a[g]),
            .resp_ready         (resp_ready),
            .resp_rdata         (resp_rdata_a[g]),
            .resp_error         (resp_error_a[g]),
            .mem_fetch_addr     (fetch_a[g]),
            .mem_write_addr     (waddr_a[g]),
            .mem_write_data     (wdata_a[g]),
            .mem_bytes_to_write (bwr_a[g]),
            .mem_fetched_data   (fetched_a[g])
        );

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
            for (int i = 0; i < 4; i++) pipe[i] = 32'd0;
        end

        always @(posedge clk) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(bwr_a[g])) mem[10'(waddr_a[g] + 32'(i))] <= wdata_a[g][8*i +: 8];
            end
            if (bwr_a[g] != 4'd0) wr_ev <= wr_ev + 1;
            pipe[0] <= {mem[10'(fetch_a[g] + 32'd3)], mem[10'(fetch_a[g] + 32'd2)],
                        mem[10'(fetch_a[g] + 32'd1)], mem[10'(fetch_a[g])]};
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        assign fetched_a[g] = pipe[RL-1];
        assign wr_ev_a[g]   = wr_ev;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_size(int f);
        return ((f % 4) == 0) ? 1 : ((f % 4) == 1) ? 2 : 4;
    endfunction

    function automatic bit m_illegal(bit st, int f, logic [31:0] a, bit ac);
        if (f == 3 || f == 6 || f == 7) return 1'b1;
        if (st && f >= 4) return 1'b1;
        if (ac && (int'(a[1:0]) % m_size(f)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(int g, int f, logic [31:0] a);
        longint v;
        int     sz;
        v  = 0;
        sz = m_size(f);
        for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[g][10'(a + 32'(i))]);
        if (f < 4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    task automatic check_quiet(input string tag);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s_ready[%0d]", tag, g), 32'(req_ready_a[g]), 32'd0);
            check($sformatf("%s_valid[%0d]", tag, g), 32'(resp_valid_a[g]), 32'd0);
            check($sformatf("%s_rdata[%0d]", tag, g), resp_rdata_a[g], 32'd0);
            check($sformatf("%s_err[%0d]", tag, g), 32'(resp_error_a[g]), 32'd0);
            check($sformatf("%s_bwr[%0d]", tag, g), 32'(bwr_a[g]), 32'd0);
            check($sformatf("%s_addr[%0d]", tag, g), fetch_a[g] | waddr_a[g] | wdata_a[g], 32'd0);
        end
    endtask

    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit          ill     [NI];
        logic [31:0] exp_rd  [NI];
        int          exp_lat [NI];
        int          lat     [NI];
        int          nw      [NI];
        int          f;
        f = int'(f3);
        for (int g = 0; g < NI; g++) begin
            ill[g]     = m_illegal(st, f, a, g == 4);
            exp_rd[g]  = (ill[g] || st) ? 32'd0 : m_load(g, f, a);
            exp_lat[g] = ill[g] ? 1 : (st ? 2 : 2 + inst_rl(g));
            lat[g]     = 0;
            nw[g]      = 0;
            if (st && !ill[g]) begin
                for (int i = 0; i < m_size(f); i++) ref_mem[g][10'(a + 32'(i))] = wd[8*i +: 8];
            end
        end
        @(negedge clk);
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (bwr_a[g] != 4'd0) begin
                    nw[g]++;
                    check($sformatf("bwr[%0d]", g), 32'(bwr_a[g]), 32'(m_size(f)));
                end
                if (resp_valid_a[g] && lat[g] == 0) begin
                    lat[g]     = n;
                    obs_rd[g]  = resp_rdata_a[g];
                    obs_err[g] = resp_error_a[g];
                    check($sformatf("rdata[%0d] f3=%0d a=%h", g, f, a), resp_rdata_a[g], exp_rd[g]);
                    check($sformatf("error[%0d] f3=%0d st=%0d", g, f, st), 32'(resp_error_a[g]), 32'(ill[g]));
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            check($sformatf("latency[%0d]", g), 32'(lat[g]), 32'(exp_lat[g]));
            check($sformatf("write_cycles[%0d]", g), 32'(nw[g]), (st && !ill[g]) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_bp [NI];
        int          ev0    [NI];
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;

        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 1024; i++) ref_mem[g][i] = 8'h00;
            obs_rd[g]  = 32'd0;
            obs_err[g] = 1'b0;
        end
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) check($sformatf("ready_after_reset[%0d]", g), 32'(req_ready_a[g]), 32'd1);

        do_txn(1'b1, 3'b010, 32'h100, 32'hdead_beef);
        do_txn(1'b1, 3'b001, 32'h100, 32'hb0ba_cafe);
        do_txn(1'b0, 3'b010, 32'h100, 32'd0);
        check("lw_after_sw_sh", obs_rd[0], 32'hdead_cafe);
        do_txn(1'b0, 3'b000, 32'h100, 32'd0);
        check("lb", obs_rd[0], 32'hffff_fffe);
        do_txn(1'b0, 3'b100, 32'h100, 32'd0);
        check("lbu", obs_rd[0], 32'h0000_00fe);
        do_txn(1'b0, 3'b001, 32'h102, 32'd0);
        check("lh", obs_rd[0], 32'hffff_dead);
        do_txn(1'b0, 3'b101, 32'h102, 32'd0);
        check("lhu", obs_rd[0], 32'h0000_dead);

        do_txn(1'b1, 3'b010, 32'h100, 32'd0);
        do_txn(1'b1, 3'b010, 32'h101, 32'haabb_ccdd);
        check("misaligned_sw_err_noalign", 32'(obs_err[0]), 32'd0);
        check("misaligned_sw_err_align", 32'(obs_err[4]), 32'd1);
        do_txn(1'b0, 3'b010, 32'h100, 32'd0);
        check("lw_misaligned_noalign", obs_rd[0], 32'hbbcc_dd00);
        check("lw_misaligned_align", obs_rd[4], 32'd0);

        do_txn(1'b0, 3'b011, 32'h100, 32'd0);
        check("illegal_load_err", 32'(obs_err[0]), 32'd1);
        check("illegal_load_rdata", obs_rd[0], 32'd0);
        do_txn(1'b1, 3'b100, 32'h104, 32'h1122_3344);
        check("illegal_store_err", 32'(obs_err[0]), 32'd1);

        repeat (40) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h100 + 32'($urandom_range(0, 63));
            do_txn(st, f3, a, $urandom);
        end

        // Backpressure: response held for 5 cycles, new requests ignored meanwhile
        for (int g = 0; g < NI; g++) exp_bp[g] = m_load(g, 2, 32'h104);
        resp_ready = 1'b0;
        @(negedge clk);
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h104;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        req_is_store = 1'b1;
        req_wdata    = 32'h7777_7777;
        req_valid    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                check($sformatf("bp_valid[%0d]", g), 32'(resp_valid_a[g]), 32'd1);
                check($sformatf("bp_rdata[%0d]", g), resp_rdata_a[g], exp_bp[g]);
                check($sformatf("bp_ready[%0d]", g), 32'(req_ready_a[g]), 32'd0);
                check($sformatf("bp_bwr[%0d]", g), 32'(bwr_a[g]), 32'd0);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) check($sformatf("bp_release[%0d]", g), 32'(resp_valid_a[g]), 32'd0);
        @(negedge clk);

        // Reset lands during a store's ISSUE cycle: the write must never reach memory
        for (int g = 0; g < NI; g++) ev0[g] = wr_ev_a[g];
        @(negedge clk);
        req_is_store = 1'b1;
        req_funct3   = 3'b010;
        req_addr     = 32'h120;
        req_wdata    = 32'h5a5a_5a5a;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bwr_pre_reset", 32'(bwr_a[0]), 32'd4);
        #2 rst = 1'b0;
        #1 check_quiet("midreset");
        repeat (2) @(negedge clk);
        check_quiet("heldreset");
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("ready_after_abort[%0d]", g), 32'(req_ready_a[g]), 32'd1);
            check($sformatf("no_resp_after_abort[%0d]", g), 32'(resp_valid_a[g]), 32'd0);
            check($sformatf("no_write_after_abort[%0d]", g), 32'(wr_ev_a[g]), 32'(ev0[g]));
        end
        do_txn(1'b0, 3'b010, 32'h120, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
